irq_unit: RTL and testbench

IRQ_UNIT -- requirements
Module: irq_unit

---
 rtl/proc12_pkg.sv | 45 ++++
 rtl/irq_prio_enc.sv | 24 ++
 rtl/irq_unit.sv | 180 ++++++++++++++++++
 tb/tb_irq_unit.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/proc12_pkg.sv
// Shared constants, state encoding and helpers for the interrupt unit.
package proc12_pkg;

    localparam int unsigned MAX_IRQ = 24;
    localparam int unsigned HALF_W  = 12;
    localparam int unsigned EXT_W   = 2 * HALF_W;
    localparam int unsigned ID_W    = 5;
    localparam int unsigned VEC_W   = 24;

    // Config register map
    localparam logic [2:0] ADDR_MASK_LO = 3'd0;
    localparam logic [2:0] ADDR_MASK_HI = 3'd1;
    localparam logic [2:0] ADDR_EDGE_LO = 3'd2;
    localparam logic [2:0] ADDR_EDGE_HI = 3'd3;
    localparam logic [2:0] ADDR_PEND_LO = 3'd4;
    localparam logic [2:0] ADDR_PEND_HI = 3'd5;
    localparam logic [2:0] ADDR_STATUS  = 3'd6;
    localparam logic [2:0] ADDR_RSVD    = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } irq_state_t;

    // One config-port transaction, narrowed to a register half
    typedef struct packed {
        logic              wr;
        logic [2:0]        addr;
        logic [HALF_W-1:0] data;
    } cfg_req_t;

    // Handler address: two words per vector table entry
    function automatic logic [VEC_W-1:0] vec_addr(input logic [VEC_W-1:0] base,
                                                  input logic [ID_W-1:0]  id);
        return base + VEC_W'({id, 1'b0});
    endfunction

    // STATUS layout: [4:0] id, [5] REQ, [6] SERVICE
    function automatic logic [HALF_W-1:0] status_word(input irq_state_t      st,
                                                      input logic [ID_W-1:0] id);
        return HALF_W'({(st == ST_SERVICE), (st == ST_REQ), id});
    endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: lowest set index wins.
module irq_prio_enc
    import proc12_pkg::*;
#(
    parameter int NUM_IRQ = 24
) (
    input  logic [NUM_IRQ-1:0] req,
    output logic               valid,
    output logic [ID_W-1:0]    id
);

    // Scan from the top so the lowest set bit is the last one written
    always_comb begin
        valid = 1'b0;
        id    = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                valid = 1'b1;
                id    = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/irq_unit.sv
// Interrupt unit: mask/edge config, pending tracking, priority select and
// request/acknowledge/end-of-interrupt handshake with the processor.
module irq_unit
    import proc12_pkg::*;
#(
    parameter int          NUM_IRQ  = 24,
    parameter int          WORD     = 12,
    parameter logic [23:0] VEC_BASE = 24'o00000100
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic               cfg_wr,
    input  logic [2:0]         cfg_addr,
    input  logic [WORD-1:0]    cfg_wdata,
    output logic [WORD-1:0]    cfg_rdata,
    output logic               irq_req,
    output logic [23:0]        irq_vector,
    input  logic               irq_ack,
    input  logic               irq_eoi
);

    irq_state_t         state;
    logic [ID_W-1:0]    id;

    logic [NUM_IRQ-1:0] mask;
    logic [NUM_IRQ-1:0] edge_sel;
    logic [NUM_IRQ-1:0] edge_pend;
    logic [NUM_IRQ-1:0] irq_prev;

    logic [NUM_IRQ-1:0] mask_nx;
    logic [NUM_IRQ-1:0] edge_nx;
    logic [NUM_IRQ-1:0] w1c;
    logic [NUM_IRQ-1:0] ack_clr;
    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] edge_pend_nx;
    logic [NUM_IRQ-1:0] pend;
    logic [NUM_IRQ-1:0] elig;

    logic [EXT_W-1:0]   mask_ext;
    logic [EXT_W-1:0]   edge_ext;
    logic [EXT_W-1:0]   pend_ext;
    logic [EXT_W-1:0]   mask_wr;
    logic [EXT_W-1:0]   edge_wr;
    logic [EXT_W-1:0]   w1c_ext;
    logic [31:0]        elig_ext;

    logic               ack_take;
    logic               id_elig;
    logic               win_valid;
    logic [ID_W-1:0]    win_id;
    logic [HALF_W-1:0]  rd;
    cfg_req_t           cfg;

    assign cfg = '{wr: cfg_wr, addr: cfg_addr, data: HALF_W'(cfg_wdata)};

    // Zero-extended views so bits at or above NUM_IRQ read as 0
    assign mask_ext = EXT_W'(mask);
    assign edge_ext = EXT_W'(edge_sel);
    assign pend_ext = EXT_W'(pend);

    // Merge config writes into the next MASK/EDGE values and the W1C set
    always_comb begin
        mask_wr = mask_ext;
        edge_wr = edge_ext;
        w1c_ext = '0;
        if (cfg.wr) begin
            case (cfg.addr)
                ADDR_MASK_LO: mask_wr[HALF_W-1:0]     = cfg.data;
                ADDR_MASK_HI: mask_wr[EXT_W-1:HALF_W] = cfg.data;
                ADDR_EDGE_LO: edge_wr[HALF_W-1:0]     = cfg.data;
                ADDR_EDGE_HI: edge_wr[EXT_W-1:HALF_W] = cfg.data;
                ADDR_PEND_LO: w1c_ext[HALF_W-1:0]     = cfg.data;
                ADDR_PEND_HI: w1c_ext[EXT_W-1:HALF_W] = cfg.data;
                default: ;
            endcase
        end
        mask_nx = NUM_IRQ'(mask_wr);
        edge_nx = NUM_IRQ'(edge_wr);
        w1c     = NUM_IRQ'(w1c_ext);
    end

    // Pending/eligibility: edge channels use the latch, level channels the live line
    always_comb begin
        ack_take     = (state == ST_REQ) && irq_ack;
        ack_clr      = ack_take ? NUM_IRQ'(32'd1 << id) : '0;
        rise         = irq & ~irq_prev;
        edge_pend_nx = rise | (edge_pend & ~(w1c | ack_clr));
        pend         = (edge_sel & edge_pend) | (~edge_sel & irq);
        elig         = pend & mask;
        elig_ext     = 32'(elig);
        id_elig      = elig_ext[id];
    end

    irq_prio_enc #(
        .NUM_IRQ (NUM_IRQ)
    ) u_prio (
        .req   (elig),
        .valid (win_valid),
        .id    (win_id)
    );

    // Config read mux, combinational from cfg_addr
    always_comb begin
        rd = '0;
        case (cfg_addr)
            ADDR_MASK_LO: rd = mask_ext[HALF_W-1:0];
            ADDR_MASK_HI: rd = mask_ext[EXT_W-1:HALF_W];
            ADDR_EDGE_LO: rd = edge_ext[HALF_W-1:0];
            ADDR_EDGE_HI: rd = edge_ext[EXT_W-1:HALF_W];
            ADDR_PEND_LO: rd = pend_ext[HALF_W-1:0];
            ADDR_PEND_HI: rd = pend_ext[EXT_W-1:HALF_W];
            ADDR_STATUS:  rd = status_word(state, id);
            ADDR_RSVD:    rd = '0;
            default:      rd = '0;
        endcase
        cfg_rdata = WORD'(rd);
    end

    // Config and pending state
    always_ff @(posedge clk) begin
        if (rst) begin
            mask      <= '0;
            edge_sel  <= '0;
            edge_pend <= '0;
            irq_prev  <= '0;
        end else begin
            mask      <= mask_nx;
            edge_sel  <= edge_nx;
            edge_pend <= edge_pend_nx;
            irq_prev  <= irq;
        end
    end

    // Request handshake FSM; id and vector are cleared whenever IDLE is re-entered
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            id         <= '0;
            irq_req    <= 1'b0;
            irq_vector <= VEC_BASE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (win_valid) begin
                        state      <= ST_REQ;
                        id         <= win_id;
                        irq_req    <= 1'b1;
                        irq_vector <= vec_addr(VEC_BASE, win_id);
                    end
                end
                ST_REQ: begin
                    if (irq_ack) begin
                        state   <= ST_SERVICE;
                        irq_req <= 1'b0;
                    end else if (!id_elig) begin
                        state      <= ST_IDLE;
                        id         <= '0;
                        irq_req    <= 1'b0;
                        irq_vector <= VEC_BASE;
                    end
                end
                ST_SERVICE: begin
                    if (irq_eoi) begin
                        state      <= ST_IDLE;
                        id         <= '0;
                        irq_vector <= VEC_BASE;
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    id         <= '0;
                    irq_req    <= 1'b0;
                    irq_vector <= VEC_BASE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_irq_unit.sv
// Self-checking bench for irq_unit: directed table, corner sequences, random vs model.
module tb_irq_unit;

    localparam logic [23:0] VB = 24'o00000100;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] irq;
    logic        cfg_wr;
    logic [2:0]  cfg_addr;
    logic [11:0] cfg_wdata;
    logic [11:0] cfg_rdata;
    logic        irq_req;
    logic [23:0] irq_vector;
    logic        irq_ack;
    logic        irq_eoi;

    int n_checks = 0;
    int n_fail   = 0;

    irq_unit dut (
        .clk        (clk),
        .rst        (rst),
        .irq        (irq),
        .cfg_wr     (cfg_wr),
        .cfg_addr   (cfg_addr),
        .cfg_wdata  (cfg_wdata),
        .cfg_rdata  (cfg_rdata),
        .irq_req    (irq_req),
        .irq_vector (irq_vector),
        .irq_ack    (irq_ack),
        .irq_eoi    (irq_eoi)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        rst = 1'b0; cfg_wr = 1'b0; cfg_addr = 3'd0; cfg_wdata = 12'd0;
        irq_ack = 1'b0; irq_eoi = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        irq = 24'd0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic cfg_write(input logic [2:0] a, input logic [11:0] d);
        cfg_wr = 1'b1; cfg_addr = a; cfg_wdata = d;
        tick();
        cfg_wr = 1'b0;
    endtask

    task automatic chk_reg(input string name, input logic [2:0] a, input logic [11:0] exp);
        cfg_addr = a;
        #1;
        check(name, 32'(cfg_rdata), 32'(exp));
    endtask

    // ---------------- behavioural model (random phase) ----------------
    bit m_mask[24];
    bit m_edge[24];
    bit m_lat[24];
    bit m_prev[24];
    int m_state;   // 0 idle, 1 requesting, 2 in service
    int m_id;

    function automatic bit m_pend(input int i);
        return m_edge[i] ? m_lat[i] : irq[i];
    endfunction

    function automatic logic [11:0] m_rd(input int a);
        logic [11:0] r = 12'd0;
        for (int b = 0; b < 12; b++) begin
            case (a)
                0: r[b] = m_mask[b];
                1: r[b] = m_mask[b + 12];
                2: r[b] = m_edge[b];
                3: r[b] = m_edge[b + 12];
                4: r[b] = m_pend(b);
                5: r[b] = m_pend(b + 12);
                default: ;
            endcase
        end
        if (a == 6)
            r = 12'(m_id) + ((m_state == 1) ? 12'd32 : 12'd0) + ((m_state == 2) ? 12'd64 : 12'd0);
        return r;
    endfunction

    task automatic model_step();
        int  win;
        bit  id_ok;
        int  nstate;
        int  nid;
        bit  took;
        bit  clr;
        win = -1; nstate = m_state; nid = m_id; took = 1'b0;
        if (rst) begin
            for (int i = 0; i < 24; i++) begin
                m_mask[i] = 0; m_edge[i] = 0; m_lat[i] = 0; m_prev[i] = 0;
            end
            m_state = 0; m_id = 0;
            return;
        end
        for (int i = 23; i >= 0; i--)
            if (m_mask[i] && m_pend(i)) win = i;
        id_ok = m_mask[m_id] && m_pend(m_id);
        if (m_state == 0) begin
            if (win >= 0) begin nstate = 1; nid = win; end
        end else if (m_state == 1) begin
            if (irq_ack) begin nstate = 2; took = 1'b1; end
            else if (!id_ok) begin nstate = 0; nid = 0; end
        end else begin
            if (irq_eoi) begin nstate = 0; nid = 0; end
        end
        for (int i = 0; i < 24; i++) begin
            clr = (took && i == m_id) ||
                  (cfg_wr && int'(cfg_addr) == 4 + i / 12 && cfg_wdata[i % 12]);
            if (irq[i] && !m_prev[i]) m_lat[i] = 1;
            else if (clr)             m_lat[i] = 0;
            if (cfg_wr && int'(cfg_addr) == i / 12)     m_mask[i] = cfg_wdata[i % 12];
            if (cfg_wr && int'(cfg_addr) == 2 + i / 12) m_edge[i] = cfg_wdata[i % 12];
            m_prev[i] = irq[i];
        end
        m_state = nstate;
        m_id    = nid;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        wr;
        logic [2:0]  addr;
        logic [11:0] wdata;
        logic [23:0] irqv;
        logic        ack;
        logic        eoi;
        logic        exp_req;
        logic [11:0] exp_rd;
        logic        chk_vec;
        logic [23:0] exp_vec;
    } vec_t;

    vec_t tbl[11];

    initial begin
        logic [23:0] v;
        int          waited;

        // edge channel 0: write config, pulse, request, ack, eoi
        tbl[0]  = '{1'b1, 3'd0, 12'o7777, 24'd0, 1'b0, 1'b0, 1'b0, 12'o0000, 1'b0, 24'd0};
        tbl[1]  = '{1'b1, 3'd2, 12'o0001, 24'd0, 1'b0, 1'b0, 1'b0, 12'o0000, 1'b0, 24'd0};
        tbl[2]  = '{1'b0, 3'd0, 12'o0000, 24'd0, 1'b0, 1'b0, 1'b0, 12'o7777, 1'b0, 24'd0};
        tbl[3]  = '{1'b0, 3'd2, 12'o0000, 24'd1, 1'b0, 1'b0, 1'b0, 12'o0001, 1'b0, 24'd0};
        tbl[4]  = '{1'b0, 3'd4, 12'o0000, 24'd0, 1'b0, 1'b0, 1'b0, 12'o0001, 1'b0, 24'd0};
        tbl[5]  = '{1'b0, 3'd6, 12'o0000, 24'd0, 1'b0, 1'b0, 1'b1, 12'o0040, 1'b1, VB};
        tbl[6]  = '{1'b0, 3'd4, 12'o0000, 24'd0, 1'b1, 1'b0, 1'b1, 12'o0001, 1'b1, VB};
        tbl[7]  = '{1'b0, 3'd4, 12'o0000, 24'd0, 1'b0, 1'b0, 1'b0, 12'o0000, 1'b1, VB};
        tbl[8]  = '{1'b0, 3'd6, 12'o0000, 24'd0, 1'b0, 1'b0, 1'b0, 12'o0100, 1'b1, VB};
        tbl[9]  = '{1'b0, 3'd6, 12'o0000, 24'd0, 1'b0, 1'b1, 1'b0, 12'o0100, 1'b1, VB};
        tbl[10] = '{1'b0, 3'd6, 12'o0000, 24'd0, 1'b0, 1'b0, 1'b0, 12'o0000, 1'b0, 24'd0};

        clear_inputs();
        irq = 24'd0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        // reset state
        check("reset_req", 32'(irq_req), 32'd0);
        check("reset_vector", 32'(irq_vector), 32'(VB));
        chk_reg("reset_mask_lo", 3'd0, 12'd0);
        chk_reg("reset_status", 3'd6, 12'd0);
        chk_reg("reg7_reads_zero", 3'd7, 12'd0);

        for (int r = 0; r < 11; r++) begin
            cfg_wr = tbl[r].wr; cfg_addr = tbl[r].addr; cfg_wdata = tbl[r].wdata;
            irq = tbl[r].irqv; irq_ack = tbl[r].ack; irq_eoi = tbl[r].eoi;
            #1;
            check($sformatf("tbl%0d_req", r), 32'(irq_req), 32'(tbl[r].exp_req));
            check($sformatf("tbl%0d_rdata", r), 32'(cfg_rdata), 32'(tbl[r].exp_rd));
            if (tbl[r].chk_vec)
                check($sformatf("tbl%0d_vector", r), 32'(irq_vector), 32'(tbl[r].exp_vec));
            tick();
        end
        clear_inputs();

        // two level channels at once: id 5 first, then id 17
        do_reset();
        cfg_write(3'd0, 12'o7777);
        cfg_write(3'd1, 12'o7777);
        irq = (24'd1 << 5) | (24'd1 << 17);
        tick();
        check("prio_req", 32'(irq_req), 32'd1);
        check("prio_vec5", 32'(irq_vector), 32'(24'o00000112));
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        irq_eoi = 1'b1; irq[5] = 1'b0; tick(); irq_eoi = 1'b0;
        waited = 0;
        while (!irq_req && waited < 8) begin tick(); waited++; end
        check("prio_req17", 32'(irq_req), 32'd1);
        check("prio_vec17", 32'(irq_vector), 32'(24'o00000142));
        chk_reg("prio_status17", 3'd6, 12'd49);

        // level drop before ack abandons the request
        do_reset();
        cfg_write(3'd0, 12'o7777);
        irq = 24'd1 << 3;
        tick();
        check("drop_req_up", 32'(irq_req), 32'd1);
        irq = 24'd0;
        #1;
        check("drop_req_same_cycle", 32'(irq_req), 32'd1);
        tick();
        check("drop_req_fell", 32'(irq_req), 32'd0);
        chk_reg("drop_status", 3'd6, 12'd0);

        // no nesting while in service
        do_reset();
        cfg_write(3'd0, 12'o7777);
        irq = 24'd1 << 2;
        tick();
        check("svc_vec2", 32'(irq_vector), 32'(24'o00000104));
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        irq[0] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("svc_nonest%0d", k), 32'(irq_req), 32'd0);
        end
        irq_eoi = 1'b1; tick(); irq_eoi = 1'b0;
        check("svc_idle_req", 32'(irq_req), 32'd0);
        tick();
        check("svc_rerequest", 32'(irq_req), 32'd1);
        check("svc_vec0", 32'(irq_vector), 32'(VB));

        // edge set coincident with W1C: set wins; later W1C alone clears
        do_reset();
        cfg_write(3'd2, 12'o0002);
        irq = 24'd1 << 1;
        cfg_write(3'd4, 12'o0002);
        chk_reg("setwins_pend", 3'd4, 12'o0002);
        cfg_write(3'd4, 12'o0002);
        chk_reg("w1c_clears", 3'd4, 12'o0000);

        // reset while in service
        do_reset();
        cfg_write(3'd0, 12'o7777);
        irq = 24'd1 << 4;
        tick();
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        chk_reg("rstsvc_status_before", 3'd6, 12'o0104);
        rst = 1'b1; irq_eoi = 1'b1; tick(); rst = 1'b0; irq_eoi = 1'b0;
        check("rstsvc_req", 32'(irq_req), 32'd0);
        check("rstsvc_vec", 32'(irq_vector), 32'(VB));
        chk_reg("rstsvc_status", 3'd6, 12'd0);
        chk_reg("rstsvc_mask", 3'd0, 12'd0);

        // random stimulus against the behavioural model
        clear_inputs();
        irq = 24'd0;
        rst = 1'b1;
        model_step();
        tick();
        for (int c = 0; c < 3000; c++) begin
            rst       = ($urandom_range(299, 0) == 0);
            cfg_wr    = ($urandom_range(5, 0) == 0);
            cfg_addr  = 3'($urandom_range(7, 0));
            cfg_wdata = 12'($urandom);
            irq_ack   = ($urandom_range(2, 0) == 0);
            irq_eoi   = ($urandom_range(4, 0) == 0);
            if ($urandom_range(3, 0) == 0) begin
                v   = 24'd1 << $urandom_range(23, 0);
                irq = irq ^ v;
            end
            #1;
            check("rnd_req", 32'(irq_req), (m_state == 1) ? 32'd1 : 32'd0);
            check("rnd_rdata", 32'(cfg_rdata), 32'(m_rd(int'(cfg_addr))));
            if (m_state != 0)
                check("rnd_vector", 32'(irq_vector), 32'(VB + 24'(2 * m_id)));
            model_step();
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
